runway_lights: RTL and testbench
================================

Name: runway_lights

Overview:
- Parametrised runway approach-light sequencer for an N-lamp strip.
- Driven by a 2-bit wind-direction input from an asynchronous sensor.
- Synchronises the wind input, paces lamp steps with a programmable prescaler, and runs one of three animation modes (calm / right-to-left / left-to-right) plus a hold mode.
- Sits between the wind sensor interface and the lamp driver outputs on the board top level.

Parameters:
- N_LAMPS, 3, number of lamps; legal range 3..32.
- SYNC_STAGES, 2, depth of the wind input synchroniser; legal range 2..4.
- TICK_DIV, 1, clock cycles per animation step; legal range 1..2^16.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- wind  input  2  raw wind code: 00 calm, 01 right-to-left (rtl), 10 left-to-right (ltr), 11 hold.
- lamps  output  N_LAMPS  lamp drive, registered; bit 0 is the rightmost lamp.
- step  output  1  one-cycle pulse in the cycle after lamps update.
- mode  output  2  current registered mode code, for debug/LEDs.

Behaviour:
- Clock and reset: already decided — one clock, clk; reset is synchronous and active-high, port named reset.
- Synchroniser: wind passes through SYNC_STAGES flops; wind_s is the last stage. All stages reset to 00.
- Prescaler:
  - Counter width max(1, $clog2(TICK_DIV)); resets to 0.
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick asserts when count == TICK_DIV-1. With TICK_DIV=1, tick is every cycle.
- Patterns:
  - OUTER = bits 0 and N_LAMPS-1 set.
  - INNER = ~OUTER.
  - R0 = one-hot bit 0.
  - L0 = one-hot bit N_LAMPS-1.
- Mode FSM states: CALM, RTL, LTR, HOLD, encoded as the wind codes. Evaluated only on tick:
  - If wind_s != mode: mode <= wind_s and lamps load the start pattern (CALM→OUTER, RTL→R0, LTR→L0). For HOLD, lamps keep their current value.
  - Else CALM: lamps toggle OUTER↔INNER. Any non-OUTER value loads OUTER.
  - Else RTL: lamps rotate left by 1 (bit N-1 wraps to bit 0).
  - Else LTR: lamps rotate right by 1 (bit 0 wraps to bit N-1).
  - Else HOLD: lamps unchanged.
- step: registered copy of tick. Asserts whenever tick fired, including in HOLD.
- Reset values: lamps = OUTER, mode = CALM, step = 0, prescaler = 0, sync chain = 0.
- Reset mid-operation: takes effect on the next edge regardless of tick; the sequence restarts from OUTER.
- Latency (TICK_DIV=1): a wind change present before edge k reaches wind_s after edge k+SYNC_STAGES-1. lamps/mode change at edge k+SYNC_STAGES.
- Wind glitches shorter than one cycle may be missed. No debouncing beyond the synchroniser.
- Lamp pattern changes only on tick edges, never between them.

Optional Feature:
- Macro: RUNWAY_LIGHTS_LAMP_TEST_EN.
- When defined:
  - Adds input port lamp_test (1 bit).
  - While lamp_test=1, lamps drives all ones combinationally from the registered sequence state.
  - Sequence, mode, prescaler and step continue unaffected.
  - Releasing lamp_test shows the current sequence value immediately.
- When undefined: no lamp_test port; lamps is the register directly.

Decomposition:
- Package runway_pkg:
  - mode_t enum {CALM=2'b00, RTL=2'b01, LTR=2'b10, HOLD=2'b11}.
  - Function outer_pattern(n).
- Sub-module sync_chain #(WIDTH, STAGES): generic flop-chain synchroniser with synchronous reset, reusable by other sensor inputs.
- Prescaler and FSM stay in runway_lights.

Test Plan:
1. N_LAMPS=4, TICK_DIV=1, SYNC_STAGES=2; reset 2 cycles, wind=00 → lamps 1001, 0110, 1001, ... alternating every cycle; step=1 each cycle after the first tick.
2. Same config, after calm run set wind=01 → mode=RTL 2 edges later, lamps=0001, then 0010, 0100, 1000, 0001 (wrap).
3. Switch wind 01→10 mid-walk (lamps=0100) → after sync latency lamps=1000, then 0100, 0010, 0001, 1000; mode=LTR.
4. TICK_DIV=3, wind=00 → lamps change only every 3rd cycle; step pulses once per 3 cycles. Wind=11 → lamps frozen, step still pulses every 3 cycles.
5. Reset asserted mid-RTL walk with prescaler at 1 → next edge: lamps=1001 (N=4), mode=CALM, step=0; with wind still 01, RTL resumes from 0001 after sync latency.
6. With RUNWAY_LIGHTS_LAMP_TEST_EN: lamp_test=1 during LTR walk → lamps=1111 same cycle; release after 5 ticks → lamps show the walk advanced by 5 positions.

Source files
------------

// File: rtl/runway_pkg.sv
// Shared types and helpers for the runway approach-light sequencer.
// Mode codes match the raw wind sensor codes one-to-one.
package runway_pkg;

  typedef enum logic [1:0] {
    CALM = 2'b00,
    RTL  = 2'b01,
    LTR  = 2'b10,
    HOLD = 2'b11
  } mode_t;

  // Outermost lamps lit: bit 0 and bit n-1.
  function automatic logic [31:0] outer_pattern(input int n);
    logic [31:0] r;
    r = '0;
    r[0] = 1'b1;
    r[n-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/runway_lights_sync_chain.sv
// Generic flop-chain synchroniser with synchronous active-high reset.
// Reusable for any asynchronous sensor input.
module sync_chain #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // Shift the raw input through the chain; all stages clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/runway_lights.sv
// Runway approach-light sequencer: wind sync, step prescaler, mode FSM.
// Optional lamp_test override: define RUNWAY_LIGHTS_LAMP_TEST_EN.
module runway_lights
  import runway_pkg::*;
#(
  parameter int N_LAMPS     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         wind,
`ifdef RUNWAY_LIGHTS_LAMP_TEST_EN
  input  logic               lamp_test,
`endif
  output logic [N_LAMPS-1:0] lamps,
  output logic               step,
  output logic [1:0]         mode
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [N_LAMPS-1:0] OUTER =
    N_LAMPS'(outer_pattern(N_LAMPS));
  localparam logic [N_LAMPS-1:0] INNER = ~OUTER;
  localparam logic [N_LAMPS-1:0] R0 = N_LAMPS'(1);
  localparam logic [N_LAMPS-1:0] L0 = {1'b1, {(N_LAMPS-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [1:0]         wind_s;
  logic [CW-1:0]      cnt;
  logic               tick;
  mode_t              mode_q;
  mode_t              wind_m;
  logic [N_LAMPS-1:0] lamp_q;
  logic               step_q;

  sync_chain #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (wind),
    .q     (wind_s)
  );

  assign tick   = (cnt == LAST);
  assign wind_m = mode_t'(wind_s);

  // Prescaler: count 0..TICK_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // Mode FSM and lamp sequence; advances only on tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= CALM;
      lamp_q <= OUTER;
      step_q <= 1'b0;
    end else begin
      step_q <= tick;
      if (tick) begin
        if (wind_m != mode_q) begin
          mode_q <= wind_m;
          unique case (wind_m)
            CALM: lamp_q <= OUTER;
            RTL:  lamp_q <= R0;
            LTR:  lamp_q <= L0;
            HOLD: lamp_q <= lamp_q;
          endcase
        end else begin
          unique case (mode_q)
            CALM: lamp_q <= (lamp_q == OUTER) ? INNER : OUTER;
            RTL:  lamp_q <= {lamp_q[N_LAMPS-2:0], lamp_q[N_LAMPS-1]};
            LTR:  lamp_q <= {lamp_q[0], lamp_q[N_LAMPS-1:1]};
            HOLD: lamp_q <= lamp_q;
          endcase
        end
      end
    end
  end

`ifdef RUNWAY_LIGHTS_LAMP_TEST_EN
  assign lamps = lamp_test ? '1 : lamp_q;
`else
  assign lamps = lamp_q;
`endif

  assign step = step_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_runway_lights.sv
// Directed bench: two sequencer instances, TICK_DIV=1 and TICK_DIV=3.
// Checks reset, calm/rtl/ltr walks, hold, mid-run reset, lamp test.
module tb_runway_lights;

  logic       clk;
  logic       reset;
  logic       reset3;
  logic [1:0] wind;
  logic [1:0] wind3;
  logic       lamp_test;
  logic [3:0] lamps;
  logic [3:0] lamps3;
  logic       step;
  logic       step3;
  logic [1:0] mode;
  logic [1:0] mode3;

  int checks;
  int failures;

  runway_lights #(
    .N_LAMPS     (4),
    .SYNC_STAGES (2),
    .TICK_DIV    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wind      (wind),
`ifdef RUNWAY_LIGHTS_LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .lamps     (lamps),
    .step      (step),
    .mode      (mode)
  );

  runway_lights #(
    .N_LAMPS     (4),
    .SYNC_STAGES (2),
    .TICK_DIV    (3)
  ) dut3 (
    .clk       (clk),
    .reset     (reset3),
    .wind      (wind3),
`ifdef RUNWAY_LIGHTS_LAMP_TEST_EN
    .lamp_test (1'b0),
`endif
    .lamps     (lamps3),
    .step      (step3),
    .mode      (mode3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [3:0] l,
                      input logic s, input logic [1:0] m);
    check({tag, ".lamps"}, {4'b0, lamps}, {4'b0, l});
    check({tag, ".step"}, {7'b0, step}, {7'b0, s});
    check({tag, ".mode"}, {6'b0, mode}, {6'b0, m});
  endtask

  task automatic chk3(input string tag, input logic [3:0] l,
                      input logic s, input logic [1:0] m);
    check({tag, ".lamps3"}, {4'b0, lamps3}, {4'b0, l});
    check({tag, ".step3"}, {7'b0, step3}, {7'b0, s});
    check({tag, ".mode3"}, {6'b0, mode3}, {6'b0, m});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    reset3 = 1'b1;
    wind = 2'b00;
    wind3 = 2'b00;
    lamp_test = 1'b0;
    cyc();
    cyc();
    chk1("rst", 4'b1001, 1'b0, 2'b00);
    chk3("rst3", 4'b1001, 1'b0, 2'b00);

    // calm alternation, one step per cycle
    reset = 1'b0;
    cyc(); chk1("calm1", 4'b0110, 1'b1, 2'b00);
    cyc(); chk1("calm2", 4'b1001, 1'b1, 2'b00);
    cyc(); chk1("calm3", 4'b0110, 1'b1, 2'b00);
    cyc(); chk1("calm4", 4'b1001, 1'b1, 2'b00);

    // rtl walk after two-stage sync latency
    wind = 2'b01;
    cyc(); chk1("rtl_lat1", 4'b0110, 1'b1, 2'b00);
    cyc(); chk1("rtl_lat2", 4'b1001, 1'b1, 2'b00);
    cyc(); chk1("rtl0", 4'b0001, 1'b1, 2'b01);
    cyc(); chk1("rtl1", 4'b0010, 1'b1, 2'b01);
    cyc(); chk1("rtl2", 4'b0100, 1'b1, 2'b01);
    cyc(); chk1("rtl3", 4'b1000, 1'b1, 2'b01);
    cyc(); chk1("rtl_wrap", 4'b0001, 1'b1, 2'b01);
    cyc(); chk1("rtl5", 4'b0010, 1'b1, 2'b01);
    cyc(); chk1("rtl6", 4'b0100, 1'b1, 2'b01);

    // switch to ltr mid-walk
    wind = 2'b10;
    cyc(); chk1("ltr_lat1", 4'b1000, 1'b1, 2'b01);
    cyc(); chk1("ltr_lat2", 4'b0001, 1'b1, 2'b01);
    cyc(); chk1("ltr0", 4'b1000, 1'b1, 2'b10);
    cyc(); chk1("ltr1", 4'b0100, 1'b1, 2'b10);
    cyc(); chk1("ltr2", 4'b0010, 1'b1, 2'b10);
    cyc(); chk1("ltr3", 4'b0001, 1'b1, 2'b10);
    cyc(); chk1("ltr_wrap", 4'b1000, 1'b1, 2'b10);

`ifdef RUNWAY_LIGHTS_LAMP_TEST_EN
    lamp_test = 1'b1;
    #1;
    chk1("lt_on", 4'b1111, 1'b1, 2'b10);
    repeat (5) cyc();
    chk1("lt_hold", 4'b1111, 1'b1, 2'b10);
    lamp_test = 1'b0;
    #1;
    chk1("lt_off", 4'b0100, 1'b1, 2'b10);
`endif

    // TICK_DIV=3: calm steps every third cycle
    reset3 = 1'b0;
    cyc(); chk3("d3_c1", 4'b1001, 1'b0, 2'b00);
    cyc(); chk3("d3_c2", 4'b1001, 1'b0, 2'b00);
    cyc(); chk3("d3_c3", 4'b0110, 1'b1, 2'b00);
    cyc(); chk3("d3_c4", 4'b0110, 1'b0, 2'b00);
    cyc(); chk3("d3_c5", 4'b0110, 1'b0, 2'b00);
    cyc(); chk3("d3_c6", 4'b1001, 1'b1, 2'b00);

    // hold freezes lamps, step keeps pulsing
    wind3 = 2'b11;
    cyc(); chk3("d3_h1", 4'b1001, 1'b0, 2'b00);
    cyc(); chk3("d3_h2", 4'b1001, 1'b0, 2'b00);
    cyc(); chk3("d3_h3", 4'b1001, 1'b1, 2'b11);
    cyc(); chk3("d3_h4", 4'b1001, 1'b0, 2'b11);
    cyc(); chk3("d3_h5", 4'b1001, 1'b0, 2'b11);
    cyc(); chk3("d3_h6", 4'b1001, 1'b1, 2'b11);

    // rtl walk, then reset with prescaler at 1
    wind3 = 2'b01;
    cyc(); chk3("d3_r1", 4'b1001, 1'b0, 2'b11);
    cyc(); chk3("d3_r2", 4'b1001, 1'b0, 2'b11);
    cyc(); chk3("d3_r3", 4'b0001, 1'b1, 2'b01);
    cyc(); chk3("d3_r4", 4'b0001, 1'b0, 2'b01);
    cyc(); chk3("d3_r5", 4'b0001, 1'b0, 2'b01);
    cyc(); chk3("d3_r6", 4'b0010, 1'b1, 2'b01);
    cyc(); chk3("d3_r7", 4'b0010, 1'b0, 2'b01);
    reset3 = 1'b1;
    cyc(); chk3("d3_mrst", 4'b1001, 1'b0, 2'b00);
    reset3 = 1'b0;
    cyc(); chk3("d3_res1", 4'b1001, 1'b0, 2'b00);
    cyc(); chk3("d3_res2", 4'b1001, 1'b0, 2'b00);
    cyc(); chk3("d3_res3", 4'b0001, 1'b1, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
